// File: rtl/iir_fold3_sched.sv
// Sequencer for a 3-folded first-order IIR section y = b0*x + b1*x1 + a1*y1,
// time-sharing one external Q10 multiplier across the three products.
module iir_fold3_sched #(
    parameter int unsigned W       = 20,
    parameter logic [W-1:0] B0_INIT = 20'd512,
    parameter logic [W-1:0] B1_INIT = 20'd256,
    parameter logic [W-1:0] A1_INIT = 20'd256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    input  logic [W-1:0] mul_p,
    input  logic         cfg_we,
    input  logic [1:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic         clr_hist,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t       state, state_nx;
    logic [W-1:0] b0, b1, a1;
    logic [W-1:0] b0_nx, b1_nx, a1_nx;
    logic [W-1:0] x_cur, x1, y1, acc;
    logic [W-1:0] x_cur_nx, x1_nx, y1_nx, acc_nx;
    logic [W-1:0] out_data_nx, mul_a_nx, mul_b_nx;
    logic         out_valid_nx, in_ready_nx, busy_nx;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            b0        <= B0_INIT;
            b1        <= B1_INIT;
            a1        <= A1_INIT;
            x_cur     <= '0;
            x1        <= '0;
            y1        <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            b0        <= b0_nx;
            b1        <= b1_nx;
            a1        <= a1_nx;
            x_cur     <= x_cur_nx;
            x1        <= x1_nx;
            y1        <= y1_nx;
            acc       <= acc_nx;
            out_data  <= out_data_nx;
            out_valid <= out_valid_nx;
            mul_a     <= mul_a_nx;
            mul_b     <= mul_b_nx;
            in_ready  <= in_ready_nx;
            busy      <= busy_nx;
        end
    end

    // Next state; multiplier operands are pre-decoded from the state being entered
    always_comb begin
        state_nx     = state;
        b0_nx        = b0;
        b1_nx        = b1;
        a1_nx        = a1;
        x_cur_nx     = x_cur;
        x1_nx        = x1;
        y1_nx        = y1;
        acc_nx       = acc;
        out_data_nx  = out_data;
        out_valid_nx = out_valid;
        mul_a_nx     = '0;
        mul_b_nx     = '0;

        case (state)
            IDLE: begin
                if (cfg_we) begin
                    case (cfg_addr)
                        2'd0:    b0_nx = cfg_data;
                        2'd1:    b1_nx = cfg_data;
                        2'd2:    a1_nx = cfg_data;
                        default: ;
                    endcase
                end
                if (clr_hist) begin
                    x1_nx = '0;
                    y1_nx = '0;
                end
                if (in_valid) begin
                    x_cur_nx = in_data;
                    state_nx = M0;
                    mul_a_nx = b0_nx;
                    mul_b_nx = in_data;
                end
            end
            M0: begin
                acc_nx   = mul_p;
                state_nx = M1;
                mul_a_nx = b1;
                mul_b_nx = x1;
            end
            M1: begin
                acc_nx   = acc + mul_p;
                state_nx = M2;
                mul_a_nx = a1;
                mul_b_nx = y1;
            end
            M2: begin
                out_data_nx  = acc + mul_p;
                out_valid_nx = 1'b1;
                state_nx     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    x1_nx        = x_cur;
                    y1_nx        = out_data;
                    out_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        in_ready_nx = (state_nx == IDLE);
        busy_nx     = (state_nx != IDLE);
    end

endmodule

// File: doc/iir_fold3_sched.md
Name: iir_fold3_sched

Overview:
- Sequencer for a 3-folded first-order IIR section: y[n] = b0·x[n] + b1·x[n-1] + a1·y[n-1].
- Time-shares one external Q10 fixed-point multiplier (20-bit operands; product = full product bits [29:10]) across the three coefficient products of each sample.
- Owns the coefficient registers, history registers, accumulator and input/output handshakes.
- Sits between the sample source and the downstream filter stage, next to the shared multiplier instance.

Parameters:
- W, 20, data/coefficient width (Q10 unsigned fixed point, 1.0 = 1024)
- B0_INIT, 20'd512, reset value of b0 (0.5)
- B1_INIT, 20'd256, reset value of b1 (0.25)
- A1_INIT, 20'd256, reset value of a1 (0.25)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample (high only in IDLE)
- in_data  in  W  input sample x[n]
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  W  output sample y[n]
- mul_a  out  W  shared multiplier operand A (coefficient)
- mul_b  out  W  shared multiplier operand B (data)
- mul_p  in  W  shared multiplier product, combinational from mul_a/mul_b
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  2  coefficient select: 0=b0, 1=b1, 2=a1, 3=reserved (write ignored)
- cfg_data  in  W  coefficient value
- clr_hist  in  1  synchronous clear of x[n-1]/y[n-1]
- busy  out  1  high in any state except IDLE

Behaviour:
- Asynchronous reset (rst_n=0):
  - state=IDLE; x_cur, x1, y1, acc, out_data = 0; out_valid=0.
  - Coefficients return to their *_INIT values.
  - Applies immediately, including mid-sequence. Any in-flight sample is discarded and history is zeroed.
- FSM states IDLE, M0, M1, M2, OUT. One state per clock.
- IDLE:
  - in_ready=1.
  - On in_valid: latch x_cur<=in_data and go to M0.
- M0: mul_a=b0, mul_b=x_cur; acc<=mul_p; go to M1.
- M1: mul_a=b1, mul_b=x1; acc<=acc+mul_p; go to M2.
- M2: mul_a=a1, mul_b=y1; out_data<=acc+mul_p; out_valid<=1; go to OUT.
- OUT:
  - out_valid=1. out_data is held stable until out_ready=1.
  - On handshake: x1<=x_cur, y1<=out_data, out_valid<=0, go to IDLE.
- In IDLE and OUT, mul_a=0 and mul_b=0 (multiplier idle).
- Latency: out_valid rises 3 clocks after the input-acceptance edge.
- Throughput: maximum one sample per 5 clocks (accept, M0, M1, M2, OUT handshake). No input is accepted until the output handshake completes.
- Arithmetic:
  - Unsigned, Q10.
  - Additions are W-bit modulo 2^W; overflow wraps and is not flagged or saturated.
  - Product truncation is done by the multiplier, not by this block.
- cfg_we:
  - Honoured only in IDLE; the coefficient updates on that edge.
  - Ignored in all other states, so coefficients are frozen for the whole M0..M2 sequence.
  - Write to addr 3 is ignored.
- clr_hist:
  - Honoured only in IDLE: x1<=0, y1<=0.
  - If clr_hist and an in_valid acceptance occur in the same cycle, the clear applies first, so the accepted sample uses zero history.
  - Ignored outside IDLE.
- Same-cycle cfg_we and acceptance in IDLE: the new coefficient is used for that sample.
- in_valid while not in_ready: no effect. in_data is sampled only at acceptance.

Test Plan:
- Reset, default coefficients, shared multiplier model attached; send x=1024 -> out_valid 3 clocks after acceptance, out_data=512; in_ready=0 until the output handshake.
- Continue with second x=1024 -> out_data=512+256+128=896; third x=0 -> out_data=0+256+224=480.
- Backpressure: hold out_ready=0 for 6 clocks in OUT -> out_valid=1, out_data stable, in_ready=0, mul_a=mul_b=0; release -> handshake, return to IDLE, history updated.
- Config: write b0=1024 in IDLE, then x=2048 from clear history -> out_data=2048. Write b0=0 while busy -> ignored, next result still uses 1024.
- Wrap: b0=1024, b1=1024, a1=0; x=0xFFFFF then x=0x00002 -> second out_data=(2+0xFFFFF) mod 2^20=0x00001.
- Reset asserted during M1 -> immediate IDLE, out_valid=0, history zeroed; next x=1024 -> out_data=512.
